// File: rtl/axil_regbank_pkg.sv
// axil_regbank_pkg: bus response codes, channel FSM state types and the
// byte-lane merge helper shared by the register bank top and write channel.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest supported bus; the merge helper works at this width and callers
  // narrow the result back to their own DATA_WIDTH.
  localparam int MAX_DW = 64;

  typedef enum logic { W_IDLE, W_RESP } wr_state_t;
  typedef enum logic { R_IDLE, R_DATA } rd_state_t;

  // Replace the bytes of old_val selected by strb with the bytes of new_val.
  function automatic logic [MAX_DW-1:0] apply_wstrb(
    input logic [MAX_DW-1:0]   old_val,
    input logic [MAX_DW-1:0]   new_val,
    input logic [MAX_DW/8-1:0] strb
  );
    logic [MAX_DW-1:0] merged;
    merged = old_val;
    for (int b = 0; b < MAX_DW/8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_regbank_wr.sv
// axil_regbank_wr: AXI4-Lite write channel (AW/W capture, commit, B response)
// plus the read-write register storage that drives the fabric control bus.
// Optional macro AXIL_REGBANK_WPULSE_EN adds a one-cycle per-register write pulse.
module axil_regbank_wr
  import axil_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RO     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ADDR_WIDTH-1:0]                  awaddr,
  input  logic                                   awvalid,
  output logic                                   awready,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  input  logic [DATA_WIDTH/8-1:0]                wstrb,
  input  logic                                   wvalid,
  output logic                                   wready,
  output logic [1:0]                             bresp,
  output logic                                   bvalid,
  input  logic                                   bready,
  output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0] ctrl
`ifdef AXIL_REGBANK_WPULSE_EN
  ,
  output logic [NUM_REGS-NUM_RO-1:0]             wr_pulse
`endif
);

  localparam int NUM_RW = NUM_REGS - NUM_RO;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam logic [IDX_W:0] NUM_RW_L = (IDX_W+1)'(NUM_RW);

  wr_state_t             state_reg, state_next;
  logic                  aw_held_reg, aw_held_next;
  logic                  w_held_reg, w_held_next;
  logic                  awready_reg, awready_next;
  logic                  wready_reg, wready_next;
  logic                  bvalid_reg, bvalid_next;
  logic [1:0]            bresp_reg, bresp_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0]     wstrb_reg, wstrb_next;

  logic                  aw_hs, w_hs, commit, idx_is_rw;
  logic [IDX_W-1:0]      cur_idx;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [STRB_W-1:0]     cur_strb;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^awaddr[LSB-1:0];

  // Commit as soon as both halves are available, whether held from an
  // earlier cycle or handshaking right now, so B follows one cycle later.
  always_comb begin
    aw_hs     = awvalid && awready_reg;
    w_hs      = wvalid && wready_reg;
    cur_idx   = aw_held_reg ? idx_reg : awaddr[ADDR_WIDTH-1:LSB];
    cur_data  = w_held_reg ? wdata_reg : wdata;
    cur_strb  = w_held_reg ? wstrb_reg : wstrb;
    commit    = (state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    idx_is_rw = ({1'b0, cur_idx} < NUM_RW_L);
  end

  // Write FSM next-state and handshake outputs.
  always_comb begin
    state_next   = state_reg;
    aw_held_next = aw_held_reg;
    w_held_next  = w_held_reg;
    awready_next = awready_reg;
    wready_next  = wready_reg;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    idx_next     = idx_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    case (state_reg)
      W_IDLE: begin
        if (commit) begin
          state_next   = W_RESP;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
          awready_next = 1'b0;
          wready_next  = 1'b0;
          bvalid_next  = 1'b1;
          bresp_next   = idx_is_rw ? RESP_OKAY : RESP_SLVERR;
        end else begin
          if (aw_hs) begin
            aw_held_next = 1'b1;
            idx_next     = cur_idx;
          end
          if (w_hs) begin
            w_held_next = 1'b1;
            wdata_next  = wdata;
            wstrb_next  = wstrb;
          end
          awready_next = !(aw_held_reg || aw_hs);
          wready_next  = !(w_held_reg || w_hs);
        end
      end
      W_RESP: begin
        if (bready) begin
          state_next   = W_IDLE;
          bvalid_next  = 1'b0;
          awready_next = 1'b1;
          wready_next  = 1'b1;
        end
      end
      default: state_next = W_IDLE;
    endcase
  end

  // Write channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      idx_reg     <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      aw_held_reg <= aw_held_next;
      w_held_reg  <= w_held_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      idx_reg     <= idx_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
    end
  end

  assign awready = awready_reg;
  assign wready  = wready_reg;
  assign bvalid  = bvalid_reg;
  assign bresp   = bresp_reg;

  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] word_reg;
      logic                  hit;
      assign hit = commit && idx_is_rw && (cur_idx == IDX_W'(gi));

      // Byte-lane update of this register on an accepted in-range write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_reg <= '0;
        else if (hit) word_reg <= DATA_WIDTH'(apply_wstrb(MAX_DW'(word_reg), MAX_DW'(cur_data),
                                                          (MAX_DW/8)'(cur_strb)));
      end
      assign ctrl[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;

`ifdef AXIL_REGBANK_WPULSE_EN
      logic pulse_reg;
      // Pulse coincides with the cycle the new register value appears.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse_reg <= 1'b0;
        else pulse_reg <= hit;
      end
      assign wr_pulse[gi] = pulse_reg;
`endif
    end
  endgenerate

endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: parametrised AXI4-Lite register bank. Lower registers are
// read-write and drive ctrl_o; the top NUM_RO registers read status_i.
// Optional macro AXIL_REGBANK_WPULSE_EN adds the wr_pulse_o output.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RO     = 2
) (
  input  logic                                        S_AXI_ACLK,
  input  logic                                        S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]                       S_AXI_AWADDR,
  input  logic [2:0]                                  S_AXI_AWPROT,
  input  logic                                        S_AXI_AWVALID,
  output logic                                        S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                       S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                     S_AXI_WSTRB,
  input  logic                                        S_AXI_WVALID,
  output logic                                        S_AXI_WREADY,
  output logic [1:0]                                  S_AXI_BRESP,
  output logic                                        S_AXI_BVALID,
  input  logic                                        S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                       S_AXI_ARADDR,
  input  logic [2:0]                                  S_AXI_ARPROT,
  input  logic                                        S_AXI_ARVALID,
  output logic                                        S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                       S_AXI_RDATA,
  output logic [1:0]                                  S_AXI_RRESP,
  output logic                                        S_AXI_RVALID,
  input  logic                                        S_AXI_RREADY,
  output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0]     ctrl_o,
  // Kept one word wide when there are no status registers.
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_i
`ifdef AXIL_REGBANK_WPULSE_EN
  ,
  output logic [NUM_REGS-NUM_RO-1:0]                  wr_pulse_o
`endif
);

  localparam int NUM_RW    = NUM_REGS - NUM_RO;
  localparam int LSB       = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W     = ADDR_WIDTH - LSB;
  localparam int NUM_SLOTS = 2 ** IDX_W;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  axil_regbank_wr #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .NUM_RO    (NUM_RO)
  ) u_wr (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .ctrl    (ctrl_o)
`ifdef AXIL_REGBANK_WPULSE_EN
    ,
    .wr_pulse(wr_pulse_o)
`endif
  );

  // Every decodable index gets a word: RW contents, status inputs, or zero.
  logic [DATA_WIDTH-1:0] rd_words [NUM_SLOTS];
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_rd
      if (gi < NUM_RW) begin : g_rw
        assign rd_words[gi] = ctrl_o[gi*DATA_WIDTH +: DATA_WIDTH];
      end else if (gi < NUM_REGS) begin : g_ro
        assign rd_words[gi] = status_i[(gi-NUM_RW)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_none
        assign rd_words[gi] = '0;
      end
    end
  endgenerate

  rd_state_t             rd_state_reg, rd_state_next;
  logic                  arready_reg, arready_next;
  logic                  rvalid_reg, rvalid_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic                  ar_hs;
  logic                  unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[LSB-1:0]};
  assign rd_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign rd_in_range   = ({1'b0, rd_idx} < NUM_REGS_L);
  assign ar_hs         = S_AXI_ARVALID && arready_reg;

  // Read FSM: capture data on AR handshake, hold it until RREADY.
  always_comb begin
    rd_state_next = rd_state_reg;
    arready_next  = arready_reg;
    rvalid_next   = rvalid_reg;
    rresp_next    = rresp_reg;
    rdata_next    = rdata_reg;
    case (rd_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_next = R_DATA;
          arready_next  = 1'b0;
          rvalid_next   = 1'b1;
          rdata_next    = rd_words[rd_idx];
          rresp_next    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          arready_next = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_next = R_IDLE;
          rvalid_next   = 1'b0;
          arready_next  = 1'b1;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  // Read channel state registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rresp_reg    <= rresp_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;

endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It is the successor to the fixed four-register bus_lite peripheral, generalised in register count, data width and read-only/read-write split. The lower registers drive fabric control outputs. The upper registers sample fabric status inputs. The block sits behind the PS/interconnect AXI4-Lite master port.

Parameters:
DATA_WIDTH, 32, bus data width; 32 or 64 only.
ADDR_WIDTH, 6, byte-address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
NUM_REGS, 8, total registers; 1..64.
NUM_RO, 2, count of read-only status registers at the top indices; 0..NUM_REGS-1.

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
ctrl_o  out  (NUM_REGS-NUM_RO)*DATA_WIDTH  RW register contents; register k occupies slice k
status_i  in  NUM_RO*DATA_WIDTH  RO register sources; sampled only on the AR handshake

Behaviour:
- Reset is asynchronous on S_AXI_ARESETN low. Release is synchronous to the S_AXI_ACLK rising edge.
- Reset values: all RW registers 0, all READY 0, BVALID/RVALID 0, BRESP/RRESP 0, RDATA 0.
- Register index is addr[ADDR_WIDTH-1:LSB], where LSB = log2(DATA_WIDTH/8). Low address bits are ignored.
- Write FSM states: W_IDLE, W_RESP.
- In W_IDLE:
  - AWREADY = 1 until AW has been captured. WREADY = 1 until W has been captured.
  - AW and W are accepted independently, in either order or in the same cycle.
- Commit occurs on the cycle both AW and W are held:
  - Index < NUM_REGS-NUM_RO: update byte lanes where WSTRB=1. BRESP = OKAY (2'b00).
  - RO index or index >= NUM_REGS: no register change. BRESP = SLVERR (2'b10).
  - The FSM moves to W_RESP with BVALID=1 on the next cycle; latency is 1 cycle after the last of the AW/W handshakes.
- In W_RESP: BVALID is held until BREADY=1. It then returns to W_IDLE with READY reasserted the following cycle. Throughput is at most one write per 2 cycles.
- Read FSM states: R_IDLE, R_DATA.
- In R_IDLE: ARREADY = 1. On the AR handshake, RDATA and RRESP are captured and the FSM moves to R_DATA with RVALID=1 on the next cycle.
  - RW index: register value.
  - RO index: status_i slice.
  - Out-of-range index: RDATA = 0, RRESP = SLVERR.
- In R_DATA: RDATA/RRESP/RVALID are held stable until RREADY. ARREADY is 0 throughout.
- Same-cycle write commit and AR handshake to the same register: read returns the pre-write value.
- Read and write channels are fully independent; no ordering between them.
- Reset mid-transaction: any pending AW/W/B/R is dropped and all VALIDs drop immediately (asynchronous).
- ctrl_o updates on the cycle after commit.

Optional Feature:
AXIL_REGBANK_WPULSE_EN
- Defined: adds output wr_pulse_o [NUM_REGS-NUM_RO-1:0]. Bit k is high for exactly one cycle, coincident with the ctrl_o update of register k. It fires only on an OKAY write to k, including a write with WSTRB=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package axil_regbank_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - enum wr_state_t {W_IDLE,W_RESP}
  - enum rd_state_t {R_IDLE,R_DATA}
  - function apply_wstrb(old,new,strb)
- Sub-module axil_regbank_wr: write channel FSM plus register storage. Read logic stays in the top level.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC, then read back. Expect each value with RRESP=OKAY, BRESP=OKAY, and ctrl_o slices matching.
2. Write 0xFFFFFFFF to reg 1, then write 0x12345678 with WSTRB=4'b0101. Read expects 0xFF34FF78.
3. Write to addr 0x18 (RO index 6) and to addr 0x3C (out of range). Expect BRESP=SLVERR and registers unchanged. Read 0x3C expects RDATA=0, RRESP=SLVERR. Set status_i[6]=0xCAFEF00D; read 0x18 expects 0xCAFEF00D, OKAY.
4. Present W three cycles before AW, with BREADY low for 5 cycles. Expect AWREADY still high after W is captured, BVALID held stable 5 cycles, and no new AW/W accepted until B completes.
5. Issue a same-cycle write commit of 0xA to reg 2 (old value 0x5) and an AR to reg 2. Expect RDATA=0x5, then a subsequent read returns 0xA. With AXIL_REGBANK_WPULSE_EN defined, wr_pulse_o[2] is high for one cycle.
6. Assert ARESETN low while BVALID and RVALID are high. Expect both VALIDs low immediately and all ctrl_o = 0. After release, a fresh write/read to reg 0 succeeds.
